captura_jogada: RTL

Debounces the seven player buttons and delivers one clean 7-bit move per physical press, plus a one-cycle load strobe. The block sits directly upstream of the 7-bit move register. `jogada` drives that register's `D` and `registra` drives its `enable`, so the register updates exactly once per press, regardless of bounce or how long the button is held.

---
 rtl/captura_jogada_if.sv | 20 ++
 rtl/captura_jogada.sv | 122 ++++++++++++
 2 files changed

// File: rtl/captura_jogada_if.sv
// Button/move bus between the debouncer and its neighbours.
// DETECTA_MULTIPLO_EN adds the erro_multiplo pulse.
interface captura_jogada_if;
   logic [6:0] botoes;
   logic [6:0] jogada;
   logic       registra;
   logic       ocupado;
`ifdef DETECTA_MULTIPLO_EN
   logic       erro_multiplo;
`endif
   logic [2:0] db_estado;

`ifdef DETECTA_MULTIPLO_EN
   modport master (output botoes, input jogada, registra, ocupado, erro_multiplo, db_estado);
   modport slave  (input botoes, output jogada, registra, ocupado, erro_multiplo, db_estado);
`else
   modport master (output botoes, input jogada, registra, ocupado, db_estado);
   modport slave  (input botoes, output jogada, registra, ocupado, db_estado);
`endif
endinterface

// File: rtl/captura_jogada.sv
// Debounces seven buttons into one 7-bit move and a one-cycle load strobe per press.
// Optional DETECTA_MULTIPLO_EN rejects multi-button presses with an erro_multiplo pulse.
module captura_jogada #(
   parameter int DEBOUNCE = 50000
) (
   input logic clock,
   input logic clear,
   captura_jogada_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      FILTRA        = 3'd1,
      CAPTURA       = 3'd2,
      ESPERA_SOLTAR = 3'd3,
      FILTRA_SOLTAR = 3'd4
   } estado_t;

   estado_t       estado, estado_n;
   logic [6:0]    sinc_a, sinc;
   logic [6:0]    amostra, amostra_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [6:0]    jogada, jogada_n;
`ifdef DETECTA_MULTIPLO_EN
   logic          erro, erro_n;
`endif

   always_ff @(posedge clock) begin
      if (clear) begin
         estado  <= OCIOSO;
         sinc_a  <= '0;
         sinc    <= '0;
         amostra <= '0;
         cnt     <= '0;
         jogada  <= '0;
`ifdef DETECTA_MULTIPLO_EN
         erro    <= 1'b0;
`endif
      end else begin
         estado  <= estado_n;
         sinc_a  <= bus.botoes;
         sinc    <= sinc_a;
         amostra <= amostra_n;
         cnt     <= cnt_n;
         jogada  <= jogada_n;
`ifdef DETECTA_MULTIPLO_EN
         erro    <= erro_n;
`endif
      end
   end

   always_comb begin
      estado_n  = estado;
      amostra_n = amostra;
      cnt_n     = cnt;
      jogada_n  = jogada;
`ifdef DETECTA_MULTIPLO_EN
      erro_n    = 1'b0;
`endif
      case (estado)
         OCIOSO: begin
            if (sinc != '0) begin
               estado_n  = FILTRA;
               amostra_n = sinc;
               cnt_n     = '0;
            end
         end
         FILTRA: begin
            if (sinc == '0) begin
               estado_n = OCIOSO;
            end else if (sinc != amostra) begin
               // a different pattern restarts the stability window
               amostra_n = sinc;
               cnt_n     = '0;
            end else if (cnt == CNT_MAX) begin
`ifdef DETECTA_MULTIPLO_EN
               if ($countones(amostra) > 1) begin
                  estado_n = ESPERA_SOLTAR;
                  erro_n   = 1'b1;
               end else begin
                  estado_n = CAPTURA;
                  jogada_n = amostra;
               end
`else
               estado_n = CAPTURA;
               jogada_n = amostra;
`endif
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         CAPTURA: estado_n = ESPERA_SOLTAR;
         ESPERA_SOLTAR: begin
            if (sinc == '0) begin
               estado_n = FILTRA_SOLTAR;
               cnt_n    = '0;
            end
         end
         FILTRA_SOLTAR: begin
            if (sinc != '0) begin
               estado_n = ESPERA_SOLTAR;
            end else if (cnt == CNT_MAX) begin
               estado_n = OCIOSO;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: estado_n = OCIOSO;
      endcase
   end

   // strobe and busy come from the registered state only
   assign bus.jogada    = jogada;
   assign bus.registra  = (estado == CAPTURA);
   assign bus.ocupado   = (estado != OCIOSO);
   assign bus.db_estado = estado;
`ifdef DETECTA_MULTIPLO_EN
   assign bus.erro_multiplo = erro;
`endif
endmodule
